// File: rtl/effect_sequencer_pkg.sv
// Shared constants, state encodings and small helpers for the effect sequencer.
package effect_sequencer_pkg;

    localparam int D_WIDTH    = 24;
    localparam int GAIN_WIDTH = 8;
    localparam int GAIN_STEP  = 8;
    localparam int RAMP_STEP  = 4;
    localparam int N_EFFECTS  = 4;
    localparam int UNITY      = 128;
    localparam int SHIFT      = 7;

    // Effect codes as seen on o_effect_sel.
    localparam logic [1:0] EFF_BYPASS = 2'd0;
    localparam logic [1:0] EFF_SWAP   = 2'd1;
    localparam logic [1:0] EFF_MONO   = 2'd2;
    localparam logic [1:0] EFF_LOCK   = 2'd3;

    // Sized copies of the numeric knobs, so arithmetic stays width-matched.
    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX_V  = {GAIN_WIDTH{1'b1}};
    localparam logic [GAIN_WIDTH-1:0] GAIN_STEP_V = GAIN_WIDTH'(GAIN_STEP);
    localparam logic [GAIN_WIDTH-1:0] UNITY_V     = GAIN_WIDTH'(UNITY);
    localparam logic [GAIN_WIDTH-1:0] RAMP_STEP_V = GAIN_WIDTH'(RAMP_STEP);
    localparam logic [1:0]            LAST_EFF_V  = 2'(N_EFFECTS - 1);

    // One state per cycle of the per-frame pipeline.
    typedef enum logic [2:0] {
        FR_IDLE   = 3'd0,
        FR_CAP    = 3'd1,
        FR_MUL_LG = 3'd2,
        FR_MUL_RG = 3'd3,
        FR_MUL_LR = 3'd4,
        FR_MUL_RR = 3'd5,
        FR_OUT    = 3'd6
    } frame_state_t;

    // Fade controller states; advanced once per completed frame.
    typedef enum logic [1:0] {
        FD_RUN      = 2'd0,
        FD_FADE_OUT = 2'd1,
        FD_FADE_IN  = 2'd2
    } fade_state_t;

    // Average of two samples; the sum is formed one bit wider so it cannot wrap.
    function automatic logic [D_WIDTH-1:0] mono_avg(input logic [D_WIDTH-1:0] a,
                                                    input logic [D_WIDTH-1:0] b);
        logic signed [D_WIDTH:0] sum;
        sum = $signed({a[D_WIDTH-1], a}) + $signed({b[D_WIDTH-1], b});
        return D_WIDTH'(sum >>> 1);
    endfunction

endpackage

// File: rtl/effect_sequencer_sat_mul_shift.sv
// Signed sample times unsigned factor, arithmetic shift by SHIFT, clamp to
// the sample range. Shared by the gain and fade passes.
module sat_mul_shift
    import effect_sequencer_pkg::*;
#(
    parameter int DW = D_WIDTH,
    parameter int BW = GAIN_WIDTH
) (
    input  logic [DW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    output logic [DW-1:0] o_y
);

    localparam int PW = DW + BW + 1;
    localparam logic signed [PW-1:0] MAX_V = {{(BW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(BW + 2){1'b1}}, {(DW - 1){1'b0}}};

    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shifted_s;

    // Multiply with the factor zero-extended, shift, then saturate.
    always_comb begin
        a_ext_s   = PW'($signed(i_a));
        b_ext_s   = PW'($signed({1'b0, i_b}));
        prod_s    = a_ext_s * b_ext_s;
        shifted_s = prod_s >>> SHIFT;
        if (shifted_s > MAX_V) begin
            o_y = MAX_V[DW-1:0];
        end else if (shifted_s < MIN_V) begin
            o_y = MIN_V[DW-1:0];
        end else begin
            o_y = shifted_s[DW-1:0];
        end
    end

endmodule

// File: rtl/effect_sequencer.sv
// Per-frame effect controller: effect mapping, gain and fade ramp through one
// shared multiplier, and a fade-out/switch/fade-in sequence on effect change.
module effect_sequencer
    import effect_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_frame_strobe,
    input  logic [D_WIDTH-1:0]    i_l_data,
    input  logic [D_WIDTH-1:0]    i_r_data,
    input  logic                  i_next_effect,
    input  logic                  i_gain_up,
    input  logic                  i_gain_down,
    output logic [D_WIDTH-1:0]    o_l_data,
    output logic [D_WIDTH-1:0]    o_r_data,
    output logic                  o_valid,
    output logic [1:0]            o_effect_sel,
    output logic [GAIN_WIDTH-1:0] o_gain,
    output logic                  o_busy,
    output logic                  o_overrun
);

    frame_state_t          state_q, state_d;
    fade_state_t           fade_q, fade_d;
    logic [D_WIDTH-1:0]    l_q, l_d, r_q, r_d;
    logic [D_WIDTH-1:0]    o_l_q, o_l_d, o_r_q, o_r_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [1:0]            effect_q, effect_d;
    logic [GAIN_WIDTH-1:0] gain_q, gain_d;
    logic [GAIN_WIDTH-1:0] ramp_q, ramp_d;
    logic                  pending_q, pending_d;
    logic                  next_prev_q, next_prev_d;
    logic                  up_prev_q, up_prev_d;
    logic                  dn_prev_q, dn_prev_d;

    logic                  next_edge_s, up_edge_s, dn_edge_s;
    logic [D_WIDTH-1:0]    mul_a_s, mul_y_s;
    logic [GAIN_WIDTH-1:0] mul_b_s;
    logic [GAIN_WIDTH-1:0] ramp_dn_s, ramp_up_s;

    assign next_edge_s = i_next_effect & ~next_prev_q;
    assign up_edge_s   = i_gain_up & ~up_prev_q;
    assign dn_edge_s   = i_gain_down & ~dn_prev_q;

    // Operand select for the shared multiplier, one pass per MUL state.
    always_comb begin
        mul_a_s = l_q;
        mul_b_s = gain_q;
        case (state_q)
            FR_MUL_LG: begin mul_a_s = l_q; mul_b_s = gain_q; end
            FR_MUL_RG: begin mul_a_s = r_q; mul_b_s = gain_q; end
            FR_MUL_LR: begin mul_a_s = l_q; mul_b_s = ramp_q; end
            FR_MUL_RR: begin mul_a_s = r_q; mul_b_s = ramp_q; end
            default:   begin mul_a_s = l_q; mul_b_s = gain_q; end
        endcase
    end

    sat_mul_shift #(
        .DW (D_WIDTH),
        .BW (GAIN_WIDTH)
    ) u_mul (
        .i_a (mul_a_s),
        .i_b (mul_b_s),
        .o_y (mul_y_s)
    );

    // Saturating one-step moves of the fade factor.
    always_comb begin
        if (ramp_q > RAMP_STEP_V) begin
            ramp_dn_s = ramp_q - RAMP_STEP_V;
        end else begin
            ramp_dn_s = '0;
        end
        if (ramp_q >= (UNITY_V - RAMP_STEP_V)) begin
            ramp_up_s = UNITY_V;
        end else begin
            ramp_up_s = ramp_q + RAMP_STEP_V;
        end
    end

    // Next-state logic: frame pipeline, fade sequence, gain buttons.
    always_comb begin
        state_d     = state_q;
        fade_d      = fade_q;
        l_d         = l_q;
        r_d         = r_q;
        o_l_d       = o_l_q;
        o_r_d       = o_r_q;
        valid_d     = 1'b0;
        overrun_d   = 1'b0;
        effect_d    = effect_q;
        gain_d      = gain_q;
        ramp_d      = ramp_q;
        pending_d   = pending_q;
        next_prev_d = i_next_effect;
        up_prev_d   = i_gain_up;
        dn_prev_d   = i_gain_down;

        // Gain buttons act at once; opposing edges cancel; locked in EFF_LOCK.
        if (effect_q != EFF_LOCK && up_edge_s && !dn_edge_s) begin
            if (gain_q > (GAIN_MAX_V - GAIN_STEP_V)) begin
                gain_d = GAIN_MAX_V;
            end else begin
                gain_d = gain_q + GAIN_STEP_V;
            end
        end else if (effect_q != EFF_LOCK && dn_edge_s && !up_edge_s) begin
            if (gain_q < GAIN_STEP_V) begin
                gain_d = '0;
            end else begin
                gain_d = gain_q - GAIN_STEP_V;
            end
        end else begin
            gain_d = gain_q;
        end

        // Effect requests are only remembered while not already fading.
        if (fade_q == FD_RUN && next_edge_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        // A strobe that cannot be accepted is flagged and dropped.
        if (state_q != FR_IDLE && i_frame_strobe) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = 1'b0;
        end

        case (state_q)
            FR_IDLE: begin
                if (i_frame_strobe) begin
                    state_d = FR_CAP;
                    case (effect_q)
                        EFF_SWAP: begin
                            l_d = i_r_data;
                            r_d = i_l_data;
                        end
                        EFF_MONO: begin
                            l_d = mono_avg(i_l_data, i_r_data);
                            r_d = mono_avg(i_l_data, i_r_data);
                        end
                        default: begin
                            l_d = i_l_data;
                            r_d = i_r_data;
                        end
                    endcase
                end else begin
                    state_d = FR_IDLE;
                end
            end
            FR_CAP:    state_d = FR_MUL_LG;
            FR_MUL_LG: begin l_d = mul_y_s; state_d = FR_MUL_RG; end
            FR_MUL_RG: begin r_d = mul_y_s; state_d = FR_MUL_LR; end
            FR_MUL_LR: begin l_d = mul_y_s; state_d = FR_MUL_RR; end
            FR_MUL_RR: begin r_d = mul_y_s; state_d = FR_OUT;    end
            FR_OUT: begin
                state_d = FR_IDLE;
                o_l_d   = l_q;
                o_r_d   = r_q;
                valid_d = 1'b1;
                // Fade factor moves once per delivered frame.
                case (fade_q)
                    FD_RUN, FD_FADE_OUT: begin
                        if (fade_q == FD_FADE_OUT || pending_q) begin
                            if (fade_q == FD_RUN) begin
                                pending_d = 1'b0;
                            end else begin
                                pending_d = pending_q;
                            end
                            ramp_d = ramp_dn_s;
                            if (ramp_dn_s == '0) begin
                                effect_d = (effect_q == LAST_EFF_V) ? 2'd0 : effect_q + 2'd1;
                                fade_d   = FD_FADE_IN;
                            end else begin
                                fade_d   = FD_FADE_OUT;
                            end
                        end else begin
                            fade_d = FD_RUN;
                        end
                    end
                    FD_FADE_IN: begin
                        ramp_d = ramp_up_s;
                        if (ramp_up_s == UNITY_V) begin
                            fade_d = FD_RUN;
                        end else begin
                            fade_d = FD_FADE_IN;
                        end
                    end
                    default: fade_d = FD_RUN;
                endcase
            end
            default: state_d = FR_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FR_IDLE;
            fade_q      <= FD_RUN;
            l_q         <= '0;
            r_q         <= '0;
            o_l_q       <= '0;
            o_r_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            effect_q    <= EFF_BYPASS;
            gain_q      <= UNITY_V;
            ramp_q      <= UNITY_V;
            pending_q   <= 1'b0;
            next_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            dn_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fade_q      <= fade_d;
            l_q         <= l_d;
            r_q         <= r_d;
            o_l_q       <= o_l_d;
            o_r_q       <= o_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            effect_q    <= effect_d;
            gain_q      <= gain_d;
            ramp_q      <= ramp_d;
            pending_q   <= pending_d;
            next_prev_q <= next_prev_d;
            up_prev_q   <= up_prev_d;
            dn_prev_q   <= dn_prev_d;
        end
    end

    assign o_l_data     = o_l_q;
    assign o_r_data     = o_r_q;
    assign o_valid      = valid_q;
    assign o_overrun    = overrun_q;
    assign o_effect_sel = effect_q;
    assign o_gain       = gain_q;
    assign o_busy       = (state_q != FR_IDLE);

endmodule

// File: tb/tb_effect_sequencer.sv
// Directed bench for effect_sequencer: a vector table for gain/bypass frames
// plus hand-written sequences for latency, overrun, fades and reset.
module tb_effect_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_frame_strobe;
    logic [23:0] i_l_data, i_r_data;
    logic        i_next_effect, i_gain_up, i_gain_down;
    logic [23:0] o_l_data, o_r_data;
    logic        o_valid;
    logic [1:0]  o_effect_sel;
    logic [7:0]  o_gain;
    logic        o_busy, o_overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          n_up;
        int          n_dn;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] el;
        logic [23:0] er;
        logic [7:0]  eg;
    } vec_t;

    vec_t        vecs[8];
    logic [23:0] ol, orr;
    int          rmp;
    logic [23:0] expv;

    always #5 clk = ~clk;

    effect_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_frame_strobe (i_frame_strobe),
        .i_l_data       (i_l_data),
        .i_r_data       (i_r_data),
        .i_next_effect  (i_next_effect),
        .i_gain_up      (i_gain_up),
        .i_gain_down    (i_gain_down),
        .o_l_data       (o_l_data),
        .o_r_data       (o_r_data),
        .o_valid        (o_valid),
        .o_effect_sel   (o_effect_sel),
        .o_gain         (o_gain),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic press_up();
        i_gain_up = 1'b1; tick(); i_gain_up = 1'b0; tick();
    endtask

    task automatic press_dn();
        i_gain_down = 1'b1; tick(); i_gain_down = 1'b0; tick();
    endtask

    task automatic press_next();
        i_next_effect = 1'b1; tick(); i_next_effect = 1'b0; tick();
    endtask

    // Strobe one pair, expect o_valid exactly six edges later for one cycle.
    task automatic do_frame(input logic [23:0] l, input logic [23:0] r,
                            output logic [23:0] ql, output logic [23:0] qr);
        i_l_data = l; i_r_data = r; i_frame_strobe = 1'b1;
        tick();
        i_frame_strobe = 1'b0;
        repeat (5) tick();
        tick();
        chk("valid_at_k6", o_valid, 1);
        ql = o_l_data;
        qr = o_r_data;
        tick();
        chk("valid_one_cycle", o_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0; i_frame_strobe = 1'b0; i_l_data = '0; i_r_data = '0;
        i_next_effect = 1'b0; i_gain_up = 1'b0; i_gain_down = 1'b0;

        //            up  dn   L          R          expL       expR       gain
        vecs[0] = '{0,  0,  24'h100000, 24'hF00000, 24'h100000, 24'hF00000, 8'd128};
        vecs[1] = '{1,  0,  24'h100000, 24'hF00000, 24'h110000, 24'hEF0000, 8'd136};
        vecs[2] = '{16, 0,  24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 8'd255};
        vecs[3] = '{0,  15, 24'h000080, 24'hFFFF80, 24'h000087, 24'hFFFF79, 8'd135};
        vecs[4] = '{0,  20, 24'h123456, 24'h800000, 24'h000000, 24'h000000, 8'd0};
        vecs[5] = '{16, 0,  24'h000003, 24'hFFFFFD, 24'h000003, 24'hFFFFFD, 8'd128};
        vecs[6] = '{1,  0,  24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 8'd136};
        vecs[7] = '{0,  1,  24'h100000, 24'hF00000, 24'h100000, 24'hF00000, 8'd128};

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_l", o_l_data, 0);
        chk("rst_r", o_r_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_eff", o_effect_sel, 0);
        chk("rst_gain", o_gain, 128);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovr", o_overrun, 0);

        // Latency and overrun: strobes at cycle 0 and cycle 2.
        i_l_data = 24'h100000; i_r_data = 24'hF00000; i_frame_strobe = 1'b1;
        tick();
        i_frame_strobe = 1'b0;
        chk("busy_after_cap", o_busy, 1);
        tick();
        i_l_data = 24'h222222; i_r_data = 24'h333333; i_frame_strobe = 1'b1;
        tick();
        i_frame_strobe = 1'b0;
        chk("overrun_pulse", o_overrun, 1);
        tick();
        chk("overrun_one_cycle", o_overrun, 0);
        tick(); tick();
        chk("no_valid_k5", o_valid, 0);
        tick();
        chk("valid_k6", o_valid, 1);
        chk("ovr_frame_l", o_l_data, 24'h100000);
        chk("ovr_frame_r", o_r_data, 24'hF00000);
        tick();
        chk("valid_k7", o_valid, 0);
        chk("idle_k7", o_busy, 0);
        chk("held_l", o_l_data, 24'h100000);

        // Vector table: gain presses then one bypass frame.
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].n_up) press_up();
            repeat (vecs[i].n_dn) press_dn();
            chk("tbl_gain", o_gain, vecs[i].eg);
            do_frame(vecs[i].l, vecs[i].r, ol, orr);
            chk("tbl_l", ol, vecs[i].el);
            chk("tbl_r", orr, vecs[i].er);
        end

        // Simultaneous up/down edges cancel; a held level steps once.
        i_gain_up = 1'b1; i_gain_down = 1'b1; tick();
        i_gain_up = 1'b0; i_gain_down = 1'b0; tick();
        chk("gain_both", o_gain, 128);
        i_gain_up = 1'b1; repeat (4) tick(); i_gain_up = 1'b0; tick();
        chk("gain_held", o_gain, 136);
        press_dn();
        chk("gain_back", o_gain, 128);

        // Fade out bypass, switch to swap, fade in; a second request mid-fade is dropped.
        press_next();
        for (int n = 1; n <= 70; n++) begin
            if (n <= 33) rmp = 128 - 4 * (n - 1);
            else rmp = (4 * (n - 33) > 128) ? 128 : 4 * (n - 33);
            expv = 24'(rmp * 32'h2000);
            do_frame(24'h100000, 24'h000000, ol, orr);
            if (n <= 32) begin
                chk("fade_l", ol, expv);
                chk("fade_r", orr, 0);
            end else begin
                chk("fade_l", ol, 0);
                chk("fade_r", orr, expv);
            end
            chk("fade_eff", o_effect_sel, (n >= 32) ? 1 : 0);
            if (n == 5) press_next();
        end

        // Move to mono.
        press_next();
        repeat (64) do_frame(24'h0, 24'h0, ol, orr);
        chk("eff_mono", o_effect_sel, 2);
        do_frame(24'h7FFFFF, 24'h7FFFFF, ol, orr);
        chk("mono_max_l", ol, 24'h7FFFFF);
        chk("mono_max_r", orr, 24'h7FFFFF);
        do_frame(24'h100000, 24'h300000, ol, orr);
        chk("mono_avg_l", ol, 24'h200000);
        chk("mono_avg_r", orr, 24'h200000);
        do_frame(24'h800000, 24'h800000, ol, orr);
        chk("mono_min_l", ol, 24'h800000);
        press_up();
        chk("gain_136", o_gain, 136);

        // Move to gain-lock: gain buttons ignored.
        press_next();
        repeat (64) do_frame(24'h0, 24'h0, ol, orr);
        chk("eff_lock", o_effect_sel, 3);
        press_up();
        chk("lock_up", o_gain, 136);
        press_dn();
        chk("lock_dn", o_gain, 136);
        do_frame(24'h100000, 24'hF00000, ol, orr);
        chk("lock_l", ol, 24'h110000);
        chk("lock_r", orr, 24'hEF0000);

        // Wrap back to bypass.
        press_next();
        repeat (64) do_frame(24'h0, 24'h0, ol, orr);
        chk("eff_wrap", o_effect_sel, 0);

        // Reset in the middle of a frame.
        do_frame(24'h100000, 24'h100000, ol, orr);
        chk("pre_rst_l", ol, 24'h110000);
        i_l_data = 24'h100000; i_r_data = 24'h100000; i_frame_strobe = 1'b1;
        tick();
        i_frame_strobe = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_l", o_l_data, 0);
        chk("mid_rst_r", o_r_data, 0);
        chk("mid_rst_gain", o_gain, 128);
        chk("mid_rst_eff", o_effect_sel, 0);
        chk("mid_rst_busy", o_busy, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_valid_after_rst", o_valid, 0);
        end
        do_frame(24'h100000, 24'hF00000, ol, orr);
        chk("post_rst_l", ol, 24'h100000);
        chk("post_rst_r", orr, 24'hF00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/effect_sequencer.md
Name: effect_sequencer

Overview:
Per-frame controller for the audio effect datapath, between the I2S transceiver receive outputs and its transmit inputs. On each frame strobe it captures one left/right sample pair and applies the selected effect: bypass, swap, mono-sum or pass-through. It then applies user gain and a click-free fade ramp through one shared multiplier, time-multiplexed over four cycles. Button-driven effect selection runs a fade-out / switch / fade-in sequence so mode changes are inaudible.

Parameters:
d_width, 24, sample width (signed two's complement)
gain_width, 8, unsigned gain register width; unity gain = 128 (gain/128)
gain_step, 8, gain change per button press
ramp_step, 4, fade factor change per frame; ramp unity = 128
n_effects, 4, number of effect modes; effect_sel wraps modulo n_effects

Ports:
clk  in  1  system clock (master audio clock domain)
reset_n  in  1  synchronous active-low reset
i_frame_strobe  in  1  one-cycle pulse: i_l_data/i_r_data hold a new valid pair
i_l_data  in  d_width  left sample received
i_r_data  in  d_width  right sample received
i_next_effect  in  1  debounced level; a rising edge requests the next effect
i_gain_up  in  1  debounced level; a rising edge adds gain_step
i_gain_down  in  1  debounced level; a rising edge subtracts gain_step
o_l_data  out  d_width  left sample to transmit; held between frames
o_r_data  out  d_width  right sample to transmit; held between frames
o_valid  out  1  one-cycle pulse when o_l_data/o_r_data update
o_effect_sel  out  2  current effect: 0 bypass, 1 swap L/R, 2 mono (L+R)>>>1, 3 bypass-with-gain-lock (gain edges ignored)
o_gain  out  gain_width  current gain
o_busy  out  1  high while the frame FSM is not in IDLE
o_overrun  out  1  one-cycle pulse when a strobe arrives while busy

Behaviour:
- Reset is synchronous, active-low. Reset values: outputs data = 0; o_valid = 0; o_effect_sel = 0; o_gain = 128; ramp = 128; fade FSM = RUN; frame FSM = IDLE; edge-detect registers = 0.
- Frame FSM: IDLE -> CAP -> MUL_LG -> MUL_RG -> MUL_LR -> MUL_RR -> OUT -> IDLE. Each state lasts one cycle.
  - CAP: register the effect-mapped pair.
    - swap: L' = R, R' = L.
    - mono: both = (L+R)>>>1, computed at d_width+1 bits.
  - MUL_xG: x = sat(x * gain >>> 7).
  - MUL_xR: x = sat(x * ramp >>> 7).
  - Single shared signed multiplier: d_width × (gain_width+1) bits, operand unsigned zero-extended.
  - sat clamps to [-2^(d_width-1), 2^(d_width-1)-1].
- Latency: strobe sampled high at edge k -> outputs and o_valid change at edge k+6. o_valid is high for exactly one cycle.
- A strobe while o_busy = 1 is dropped and pulses o_overrun. In-flight frame completes unchanged.
- Fade FSM states RUN, FADE_OUT, FADE_IN. It updates only in the OUT cycle.
  - RUN: a pending next-effect request moves to FADE_OUT.
  - FADE_OUT: ramp = max(ramp - ramp_step, 0). When ramp reaches 0: effect_sel = (effect_sel+1) mod n_effects, go to FADE_IN.
  - FADE_IN: ramp = min(ramp + ramp_step, 128). Reaching 128 -> RUN.
  - With defaults, the new effect is applied from the 33rd OUT after the request; RUN is regained after 64 frames.
- Next-effect edges set a one-deep pending flag, cleared on entry to FADE_OUT. Edges arriving while not in RUN are discarded; the pending flag never sets outside RUN.
- Gain edges take effect immediately, whatever the frame FSM state. They are sampled by the multiplier from the next MUL_xG onward.
  - Gain saturates at 0 and 2^gain_width - 1.
  - Simultaneous up and down edges: no change.
  - Gain edges are ignored when effect_sel = 3.
- Edge detection: rising edge = input high and previous-cycle register low.
- Reset asserted mid-frame: FSM returns to IDLE next edge, no o_valid, outputs zeroed.

Decomposition:
- Shared package holds:
  - effect code constants: EFF_BYPASS = 0, EFF_SWAP = 1, EFF_MONO = 2, EFF_LOCK = 3
  - UNITY = 128, SHIFT = 7
  - frame FSM state encodings
  - fade FSM state encodings
- One natural sub-module: sat_mul_shift. Combinational signed×unsigned multiply, arithmetic shift, clamp. Reused for both gain and ramp passes.

Test Plan:
- Reset, gain 128, bypass, strobe with L = 0x100000, R = 0xF00000 -> after 6 cycles o_l_data = 0x100000, o_r_data = 0xF00000, o_valid one cycle.
- One i_gain_up edge (gain 136), L = 0x100000 -> o_l_data = 0x110000; 16 up edges -> o_gain = 255 (saturated). Then L = 0x7FFFFF -> 0x7FFFFF and L = 0x800000 -> 0x800000 (clamped).
- i_next_effect edge, then 70 strobes with L = 0x100000, R = 0x000000 -> ramp steps 124, 120, … 0; o_effect_sel = 1 after 32nd OUT. Then o_r_data ramps up carrying 0x100000 scaled by the rising fade factor; RUN after 64 frames. Second edge during fade ignored.
- Effect 2, L = 0x7FFFFF, R = 0x7FFFFF -> both outputs 0x7FFFFF (no wrap in sum).
- Strobe at cycle 0 and cycle 2 -> single o_valid at cycle 6, o_overrun pulse at cycle 2.
- reset_n low at cycle 3 of a frame -> no o_valid, outputs 0, o_gain = 128, o_effect_sel = 0 next edge.
